// File: rtl/spi_master_clkgen.sv
// spi_master_clkgen
//   SPI serial-clock generator (mode 0, spi_clk idles low). Divides clk into
//   spi_clk with a half period of div_q+1 cycles, and issues one-cycle
//   spi_rise / spi_fall strobes registered with each spi_clk toggle.
//   The clock only ever stops in the low phase, so the pad never sees a
//   truncated high pulse (except on synchronous reset).
//
// Ports
//   clk           in   system clock, rising edge
//   rst           in   synchronous active-high reset
//   en            in   run request (OR of RX/TX clock enables)
//   clk_div       in   divider value, half period = clk_div+1 cycles
//   clk_div_valid in   one-cycle strobe loading clk_div
//   spi_clk       out  registered serial clock
//   spi_rise      out  strobe, first cycle spi_clk is high
//   spi_fall      out  strobe, first cycle spi_clk is low after a high phase
//   running       out  generator is in RUN
module spi_master_clkgen #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] clk_div,
  input  logic             clk_div_valid,
  output logic             spi_clk,
  output logic             spi_rise,
  output logic             spi_fall,
  output logic             running
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_n;
  logic [DIV_W-1:0] cnt, cnt_n;
  logic [DIV_W-1:0] div_q, div_q_n;
  logic [DIV_W-1:0] div_pend, div_pend_n;
  logic             pend_v, pend_v_n;
  logic             spi_clk_n, spi_rise_n, spi_fall_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      div_q    <= '0;
      div_pend <= '0;
      pend_v   <= 1'b0;
      spi_clk  <= 1'b0;
      spi_rise <= 1'b0;
      spi_fall <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      div_q    <= div_q_n;
      div_pend <= div_pend_n;
      pend_v   <= pend_v_n;
      spi_clk  <= spi_clk_n;
      spi_rise <= spi_rise_n;
      spi_fall <= spi_fall_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    div_q_n    = div_q;
    div_pend_n = div_pend;
    pend_v_n   = pend_v;
    spi_clk_n  = spi_clk;
    spi_rise_n = 1'b0;
    spi_fall_n = 1'b0;

    case (state)
      IDLE: begin
        spi_clk_n = 1'b0;
        cnt_n     = '0;
        if (clk_div_valid) begin
          div_q_n = clk_div;
        end else if (pend_v) begin
          div_q_n  = div_pend;
          pend_v_n = 1'b0;
        end
        if (en) begin
          state_n = RUN;
        end
      end

      RUN: begin
        // Divider changes mid-run are parked until the next IDLE so the
        // current period is never distorted.
        if (clk_div_valid) begin
          div_pend_n = clk_div;
          pend_v_n   = 1'b1;
        end

        // Stopping in the low phase takes priority over an expiry, which
        // suppresses a rise that would otherwise start a new high pulse.
        if (!en && !spi_clk) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == div_q) begin
          cnt_n     = '0;
          spi_clk_n = ~spi_clk;
          if (!spi_clk) begin
            spi_rise_n = 1'b1;
          end else begin
            spi_fall_n = 1'b1;
            if (!en) begin
              state_n = IDLE;
            end
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign running = (state == RUN);

endmodule
